// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: entry state encoding and default bundle widths.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 24;
    localparam int unsigned DATA_W_DEF = 143;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            HALF:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready beat bundle carrying the control and data halves of a pipeline stage.
interface pipe_skid_reg_if #(
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg_slot.sv
// One storage entry: loadable control/data pair whose control can be cleared to a bubble.
module pipe_slot #(
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear only zeroes control; data keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_clear) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush and bubble insertion.
module pipe_skid_reg #(
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);
    import pipe_pkg::*;

    pipe_state_e       r_state;
    pipe_state_e       w_next;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [1:0]        r_occ;

    logic              w_acc;
    logic              w_dlv;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_main_clear;
    logic              w_skid_load;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    assign w_acc = IN_VALID & IN_READY;
    assign w_dlv = r_out_valid & OUT_READY;

    // With the skid entry, ready is registered so OUT_READY never reaches IN_READY combinationally.
    assign IN_READY = (SKID != 0) ? r_in_ready : (~r_out_valid | OUT_READY);

    always_comb begin
        w_next           = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_next      = HALF;
                    w_main_load = 1'b1;
                end
            end
            HALF: begin
                if (w_acc && w_dlv) begin
                    w_main_load = 1'b1;
                end else if (w_acc && (SKID != 0)) begin
                    w_next      = FULL;
                    w_skid_load = 1'b1;
                end else if (w_dlv) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                if (w_dlv) begin
                    w_next           = HALF;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
        if (FLUSH) begin
            w_next      = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    // Clearing the main control whenever the stage empties keeps OUT_CTRL a bubble without an output mux.
    assign w_main_clear   = (w_next == EMPTY);
    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : IN_CTRL;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : IN_DATA;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next != EMPTY);
            r_in_ready  <= (w_next != FULL);
            r_occ       <= occ_of(w_next);
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (CLOCK),
        .rst     (RESET),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (CLOCK),
                .rst     (RESET),
                .i_load  (w_skid_load),
                .i_clear (FLUSH),
                .i_ctrl  (IN_CTRL),
                .i_data  (IN_DATA),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end else begin : g_noskid
            logic w_unused_skid;
            assign w_unused_skid = w_skid_load;
            assign w_skid_ctrl   = '0;
            assign w_skid_data   = '0;
        end
    endgenerate

    assign OUT_VALID = r_out_valid;
    assign OUT_CTRL  = w_main_ctrl;
    assign OUT_DATA  = w_main_data;
    assign OCCUPANCY = r_occ;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a two-entry list model checked every cycle against SKID=1 and SKID=0 instances.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int CW = CTRL_W_DEF;
    localparam int DW = DATA_W_DEF;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    int            sel;
    logic [1:0]    occ0, occ1;

    int n_chk  = 0;
    int n_pass = 0;
    int obs0[$];
    int obs1[$];
    bit stream_done;
    int max_occ0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();
    pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();

    assign up0.valid = in_valid && (sel == 0);
    assign up1.valid = in_valid && (sel == 1);
    assign up0.ctrl  = in_ctrl;
    assign up1.ctrl  = in_ctrl;
    assign up0.data  = in_data;
    assign up1.data  = in_data;
    assign dn0.ready = out_ready;
    assign dn1.ready = out_ready;

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .CLOCK(clk), .RESET(rst), .FLUSH(flush),
        .IN_VALID(up1.valid), .IN_READY(up1.ready), .IN_CTRL(up1.ctrl), .IN_DATA(up1.data),
        .OUT_VALID(dn1.valid), .OUT_READY(dn1.ready), .OUT_CTRL(dn1.ctrl), .OUT_DATA(dn1.data),
        .OCCUPANCY(occ1)
    );

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .CLOCK(clk), .RESET(rst), .FLUSH(flush),
        .IN_VALID(up0.valid), .IN_READY(up0.ready), .IN_CTRL(up0.ctrl), .IN_DATA(up0.data),
        .OUT_VALID(dn0.valid), .OUT_READY(dn0.ready), .OUT_CTRL(dn0.ctrl), .OUT_DATA(dn0.data),
        .OCCUPANCY(occ0)
    );

    logic          o_v[2];
    logic [CW-1:0] o_c[2];
    logic [DW-1:0] o_d[2];
    logic [1:0]    o_o[2];
    logic          i_r[2];
    assign o_v[0] = dn0.valid;  assign o_v[1] = dn1.valid;
    assign o_c[0] = dn0.ctrl;   assign o_c[1] = dn1.ctrl;
    assign o_d[0] = dn0.data;   assign o_d[1] = dn1.data;
    assign o_o[0] = occ0;       assign o_o[1] = occ1;
    assign i_r[0] = up0.ready;  assign i_r[1] = up1.ready;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] mk_data(input int k);
        logic [DW-1:0] v;
        v = DW'(k);
        return (v << 80) | (v << 8) | DW'(8'h5A);
    endfunction

    // Model: each DUT holds an ordered list of at most two beats; index 0 is the head.
    int            m_cnt[2];
    logic [CW-1:0] m_c[2][2];
    logic [DW-1:0] m_d[2][2];
    logic [DW-1:0] m_last[2];
    bit            m_arm[2];

    function automatic bit exp_rdy(input int d);
        if (d == 1) return m_arm[1] && (m_cnt[1] < 2);
        return (m_cnt[0] == 0) || out_ready;
    endfunction

    initial begin : model
        bit acc, dlv;
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    m_cnt[d]  = 0;
                    m_arm[d]  = 1'b0;
                    m_last[d] = '0;
                end else begin
                    acc = in_valid && (sel == d) && exp_rdy(d);
                    dlv = (m_cnt[d] > 0) && out_ready;
                    if (flush) begin
                        m_cnt[d] = 0;
                    end else begin
                        if (dlv) begin
                            m_c[d][0] = m_c[d][1];
                            m_d[d][0] = m_d[d][1];
                            m_cnt[d]  = m_cnt[d] - 1;
                        end
                        if (acc) begin
                            m_c[d][m_cnt[d]] = in_ctrl;
                            m_d[d][m_cnt[d]] = in_data;
                            m_cnt[d]         = m_cnt[d] + 1;
                        end
                    end
                    if (m_cnt[d] > 0) m_last[d] = m_d[d][0];
                    m_arm[d] = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        bit ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    ev = (m_cnt[d] > 0);
                    check($sformatf("d%0d OUT_VALID", d), 256'(o_v[d]), 256'(ev));
                    check($sformatf("d%0d OUT_CTRL", d), 256'(o_c[d]), ev ? 256'(m_c[d][0]) : 256'(0));
                    check($sformatf("d%0d OUT_DATA", d), 256'(o_d[d]), ev ? 256'(m_d[d][0]) : 256'(m_last[d]));
                    check($sformatf("d%0d OCCUPANCY", d), 256'(o_o[d]), 256'(m_cnt[d]));
                    check($sformatf("d%0d IN_READY", d), 256'(i_r[d]), 256'(exp_rdy(d)));
                    if (o_v[d] && out_ready) begin
                        if (d == 1) obs1.push_back(int'(o_c[d]));
                        else        obs0.push_back(int'(o_c[d]));
                    end
                end
                if (int'(occ0) > max_occ0) max_occ0 = int'(occ0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = CW'(k);
        in_data  = mk_data(k);
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = (sel == 1) ? up1.ready : up0.ready;
            tick();
        end
        in_valid = 1'b0;
        check($sformatf("accept beat %0d", k), 256'(acc), 256'(1));
    endtask

    function automatic int obs_at(input int d, input int i);
        if (d == 1) return (i < obs1.size()) ? obs1[i] : -1;
        return (i < obs0.size()) ? obs0[i] : -1;
    endfunction

    task automatic stream(input int d, input int base);
        int n_bad = 0;
        int n_obs;
        sel = d;
        if (d == 1) obs1.delete(); else obs0.delete();
        stream_done = 1'b0;
        fork
            begin
                while (!stream_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join_none
        for (int i = 0; i < 100; i++) begin
            if (i % 23 == 22) tick();
            send(base + i);
        end
        stream_done = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (4) tick();
        n_obs = (d == 1) ? obs1.size() : obs0.size();
        check($sformatf("stream d%0d count", d), 256'(n_obs), 256'(100));
        for (int i = 0; i < 100; i++) if (obs_at(d, i) != base + i) n_bad++;
        check($sformatf("stream d%0d order", d), 256'(n_bad), 256'(0));
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL global timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int n9;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 1; in_ctrl = '0; in_data = '0; stream_done = 1'b0;
        repeat (2) tick();
        check("reset OUT_VALID", 256'(dn1.valid), 256'(0));
        check("reset OUT_CTRL", 256'(dn1.ctrl), 256'(0));
        check("reset OUT_DATA", 256'(dn1.data), 256'(0));
        check("reset OCCUPANCY", 256'(occ1), 256'(0));
        check("reset IN_READY", 256'(up1.ready), 256'(0));
        rst = 1'b0;
        tick();
        check("IN_READY first edge", 256'(up1.ready), 256'(1));

        // Single beat, 1-cycle latency, then bubble with data held.
        out_ready = 1'b1; obs1.delete();
        in_valid = 1'b1; in_ctrl = 24'h00ABCD; in_data = mk_data(7);
        tick();
        in_valid = 1'b0;
        check("single OUT_VALID", 256'(dn1.valid), 256'(1));
        check("single OUT_CTRL", 256'(dn1.ctrl), 256'(24'h00ABCD));
        tick();
        check("single after OUT_VALID", 256'(dn1.valid), 256'(0));
        check("single after OUT_CTRL", 256'(dn1.ctrl), 256'(0));
        check("single after OUT_DATA", 256'(dn1.data), 256'(mk_data(7)));

        // Back-pressure: 1..4 with OUT_READY low, then released.
        out_ready = 1'b0; obs1.delete();
        send(1); send(2);
        check("bp OCCUPANCY", 256'(occ1), 256'(2));
        check("bp IN_READY", 256'(up1.ready), 256'(0));
        out_ready = 1'b1;
        send(3); send(4);
        repeat (4) tick();
        check("bp count", 256'(obs1.size()), 256'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("bp order %0d", i), 256'(obs_at(1, i)), 256'(i + 1));

        // Flush in FULL and in HALF with a beat 9 offered.
        out_ready = 1'b0; obs1.delete();
        send(5); send(6);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = CW'(9); in_data = mk_data(9);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush full OCCUPANCY", 256'(occ1), 256'(0));
        check("flush full OUT_VALID", 256'(dn1.valid), 256'(0));
        check("flush full OUT_CTRL", 256'(dn1.ctrl), 256'(0));
        send(10);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = CW'(9); in_data = mk_data(9);
        check("flush half IN_READY", 256'(up1.ready), 256'(1));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush half OCCUPANCY", 256'(occ1), 256'(0));
        check("flush half OUT_VALID", 256'(dn1.valid), 256'(0));
        out_ready = 1'b1;
        repeat (4) tick();
        n9 = 0;
        foreach (obs1[i]) if (obs1[i] == 9) n9++;
        check("flush beat 9 seen", 256'(n9), 256'(0));
        check("flush nothing delivered", 256'(obs1.size()), 256'(0));

        // Delivery in the same cycle as FLUSH is completed.
        out_ready = 1'b0; obs1.delete();
        send(11);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush+deliver count", 256'(obs1.size()), 256'(1));
        check("flush+deliver beat", 256'(obs_at(1, 0)), 256'(11));
        check("flush+deliver OUT_VALID", 256'(dn1.valid), 256'(0));

        // Asynchronous reset while FULL.
        out_ready = 1'b0; obs1.delete();
        send(20); send(21);
        #2;
        rst = 1'b1;
        #1;
        check("async rst OUT_VALID", 256'(dn1.valid), 256'(0));
        check("async rst OUT_CTRL", 256'(dn1.ctrl), 256'(0));
        check("async rst OUT_DATA", 256'(dn1.data), 256'(0));
        check("async rst OCCUPANCY", 256'(occ1), 256'(0));
        check("async rst IN_READY", 256'(up1.ready), 256'(0));
        tick();
        rst = 1'b0;
        check("rst release IN_READY", 256'(up1.ready), 256'(0));
        tick();
        check("rst edge IN_READY", 256'(up1.ready), 256'(1));
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst beats discarded", 256'(obs1.size()), 256'(0));

        stream(1, 1000);
        stream(0, 2000);
        check("SKID0 occupancy max", 256'(max_occ0 <= 1), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
